// File: rtl/pll_supervisor.sv
// pll_supervisor
//   Sequences an iCE40 PLL from its reference clock. The block holds the PLL
//   in reset for a fixed time and then waits for LOCK. It qualifies LOCK over
//   a stable window before releasing the output-domain reset. If lock is lost,
//   or if lock never arrives in time, it restarts the PLL. Two saturating
//   counters record those events for diagnostics.
//
// Ports
//   clock_in      reference clock; all state changes on its rising edge
//   reset         asynchronous active-high reset of the whole block
//   pll_locked    PLL LOCK flag, asynchronous to clock_in
//   clear_counts  synchronous clear of loss_count and retry_count
//   pll_resetb    active-low PLL reset (to RESETB)
//   domain_reset  active-high reset for the PLL output clock domain
//   ready         high while the PLL is qualified as locked
//   loss_count    lock losses seen while running, saturating
//   retry_count   lock-wait timeouts, saturating
module pll_supervisor #(
    parameter int unsigned PLL_RESET_CYCLES      = 8,
    parameter int unsigned LOCK_STABLE_CYCLES    = 1024,
    parameter int unsigned RELOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned COUNT_WIDTH           = 8
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   clear_counts,
    output logic                   pll_resetb,
    output logic                   domain_reset,
    output logic                   ready,
    output logic [COUNT_WIDTH-1:0] loss_count,
    output logic [COUNT_WIDTH-1:0] retry_count
);

    localparam int unsigned MAX_AB  = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_AB > RELOCK_TIMEOUT_CYCLES) ?
                                      MAX_AB : RELOCK_TIMEOUT_CYCLES;
    // The phase counter only ever has to reach MAX_ALL-1.
    localparam int unsigned PHASE_W = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [PHASE_W-1:0] RESET_LAST   = PHASE_W'(PLL_RESET_CYCLES - 1);
    localparam logic [PHASE_W-1:0] STABLE_LAST  = PHASE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TIMEOUT_LAST = PHASE_W'(RELOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PHASE_W-1:0]   phase;
    logic                 sync1;
    logic                 lock_s;
    logic                 loss_inc;
    logic                 retry_inc;

    // State register, phase counter, lock synchroniser and event counters.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state       <= PLL_RESET;
            phase       <= '0;
            sync1       <= 1'b0;
            lock_s      <= 1'b0;
            loss_count  <= '0;
            retry_count <= '0;
        end else begin
            state  <= state_next;
            sync1  <= pll_locked;
            lock_s <= sync1;

            // The phase counter restarts from zero on every state change.
            // In RUN it is never compared, so letting it wrap there is harmless.
            if (state_next != state) begin
                phase <= '0;
            end else begin
                phase <= phase + PHASE_W'(1);
            end

            // clear_counts takes priority over a coincident increment.
            if (clear_counts) begin
                loss_count  <= '0;
                retry_count <= '0;
            end else begin
                if (loss_inc && (loss_count != '1)) begin
                    loss_count <= loss_count + COUNT_WIDTH'(1);
                end
                if (retry_inc && (retry_count != '1)) begin
                    retry_count <= retry_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // Next-state logic and event strobes.
    always_comb begin
        state_next = state;
        loss_inc   = 1'b0;
        retry_inc  = 1'b0;
        unique case (state)
            PLL_RESET: begin
                if (phase == RESET_LAST) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // If lock arrives on the same cycle as the timeout, lock wins.
                if (lock_s) begin
                    state_next = STABLE;
                end else if (phase == TIMEOUT_LAST) begin
                    state_next = PLL_RESET;
                    retry_inc  = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (phase == STABLE_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = PLL_RESET;
                    loss_inc   = 1'b1;
                end
            end
            default: state_next = PLL_RESET;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        pll_resetb   = (state != PLL_RESET);
        domain_reset = (state != RUN);
        ready        = (state == RUN);
    end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Parametrised supervisor for an iCE40 PLL, clocked from the PLL's reference clock. It drives the PLL's active-low reset and synchronises the asynchronous lock flag. It qualifies lock over a programmable stable window, then releases a reset for the PLL output domain. On lock loss or lock timeout it restarts the PLL and keeps saturating event counters for diagnostics.

## Interface
- PLL_RESET_CYCLES, 8: cycles `pll_resetb` is held low per PLL restart; ≥1.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before release; ≥1.
- RELOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a restart; ≥1.
- COUNT_WIDTH, 8: width of `loss_count` and `retry_count`.
- clock_in  input  1  reference clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset for the whole block.
- pll_locked  input  1  PLL LOCK flag, asynchronous to `clock_in`.
- clear_counts  input  1  synchronous clear of both counters.
- pll_resetb  output  1  active-low PLL reset, wired to RESETB.
- domain_reset  output  1  active-high reset for the PLL output domain.
- ready  output  1  high while the PLL is qualified as locked.
- loss_count  output  COUNT_WIDTH  lock losses seen in RUN; saturating.
- retry_count  output  COUNT_WIDTH  WAIT_LOCK timeouts; saturating.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lock_s`. Both flops reset to 0.
- One phase counter is shared by all states. It is zeroed on every state transition and sized `$clog2` of the largest parameter.
- States:
  - PLL_RESET (reset state): `pll_resetb`=0. When counter = PLL_RESET_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: if `lock_s`=1, go to STABLE. Otherwise, when counter = RELOCK_TIMEOUT_CYCLES-1, go to PLL_RESET and increment `retry_count`. If both are true in the same cycle, lock wins.
  - STABLE: if `lock_s`=0, return to WAIT_LOCK; the timeout window restarts from 0. When counter = LOCK_STABLE_CYCLES-1 and `lock_s`=1, go to RUN.
  - RUN: if `lock_s`=0, go to PLL_RESET and increment `loss_count`.
- Outputs are Moore-decoded from the state register with no extra register stage:
  - `pll_resetb` = (state ≠ PLL_RESET).
  - `domain_reset` = (state ≠ RUN).
  - `ready` = (state = RUN).
- Counters:
  - Increment by 1 and saturate at 2^COUNT_WIDTH-1.
  - `clear_counts` zeroes both counters on the next edge.
  - If `clear_counts` coincides with an increment, the clear wins and the result is 0.
- Reset values: state PLL_RESET, phase counter 0, `pll_resetb`=0, `domain_reset`=1, `ready`=0, `loss_count`=0, `retry_count`=0.
- Asserting `reset` at any time, including mid-RUN, forces the reset values immediately without waiting for a clock edge. After release, sequencing restarts from PLL_RESET.

## Timing
- PLL restart: after `reset` deasserts or PLL_RESET is entered, `pll_resetb` is low for exactly PLL_RESET_CYCLES rising edges.
- Lock qualification: number the first edge that samples `pll_locked`=1 in WAIT_LOCK as edge 1.
  - `lock_s` is high after edge 2.
  - STABLE is entered at edge 3.
  - `ready` rises and `domain_reset` falls at edge LOCK_STABLE_CYCLES+3, provided lock stayed high throughout.
- Lock loss: number the first edge sampling `pll_locked`=0 in RUN as edge 1. At edge 3, `ready` falls, `domain_reset` rises, `pll_resetb` falls and `loss_count` increments.
- A lock glitch in STABLE shorter than 1 cycle may be missed by the synchroniser; that is acceptable. Any glitch visible on `lock_s` restarts qualification.
- Timeout: `retry_count` increments on the edge where WAIT_LOCK has spent RELOCK_TIMEOUT_CYCLES cycles without `lock_s`.

## Test plan
Parameters for all scenarios: PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, RELOCK_TIMEOUT_CYCLES=32, COUNT_WIDTH=2.

- Reset release with `pll_locked`=0 throughout -> `pll_resetb` low 4 cycles then high for 32 cycles. `retry_count`=1 and `pll_resetb` low 4 cycles again; after 3 more timeouts `retry_count` stays 3.
- `pll_locked` rises during WAIT_LOCK and stays high -> `ready`=1 and `domain_reset`=0 from edge 11 (edge 1 = first sample high); `loss_count`=0.
- Lock high 5 cycles in STABLE, low 3 cycles, then high -> `ready` stays 0 through the glitch. `ready` rises 11 edges after the second rising sample, and no counter changes.
- In RUN, drop `pll_locked` -> at edge 3 `ready`=0, `domain_reset`=1, `pll_resetb`=0, `loss_count`=1. `pll_resetb` stays low exactly 4 cycles.
- 4 lock losses -> `loss_count` saturates at 3. Pulse `clear_counts` on the edge of a fifth loss -> `loss_count`=0 afterwards.
- Assert `reset` asynchronously mid-RUN between clock edges -> `ready`=0, `domain_reset`=1, `pll_resetb`=0 and counts 0 before the next edge. After release the 4-cycle PLL reset repeats.
